// File: rtl/mp_add_pkg.sv
// Shared types and defaults for the multi-precision add/subtract sequencer.
package mp_add_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    localparam int unsigned WORD_W_DEF    = 16;
    localparam int unsigned NUM_WORDS_DEF = 4;

    // Width of the word index; at least one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mp_word_adder.sv
// Combinational WORD_W-bit ripple adder slice with carry-in/carry-out and the
// carry into the MSB (used for signed-overflow detection).
module mp_word_adder #(
    parameter int unsigned WORD_W = 16
) (
    input  logic [WORD_W-1:0] a_i,
    input  logic [WORD_W-1:0] b_i,
    input  logic              cin_i,
    output logic [WORD_W-1:0] sum_o,
    output logic              cout_o,
    output logic              c_msb_o
);

    logic [WORD_W:0] carry;

    // Bit-level ripple chain.
    always_comb begin
        carry    = '0;
        sum_o    = '0;
        carry[0] = cin_i;
        for (int i = 0; i < WORD_W; i++) begin
            sum_o[i]     = a_i[i] ^ b_i[i] ^ carry[i];
            carry[i + 1] = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
        end
        cout_o  = carry[WORD_W];
        c_msb_o = carry[WORD_W-1];
    end

endmodule

// File: rtl/mp_add_ctrl.sv
// Multi-precision add/subtract sequencer: walks one shared WORD_W-bit slice over
// NUM_WORDS words, LSW first, chaining the carry through a register.
// Optional feature: define MP_ADD_OVF_EN to enable signed-overflow output.
module mp_add_ctrl
    import mp_add_pkg::*;
#(
    parameter int unsigned WORD_W    = WORD_W_DEF,
    parameter int unsigned NUM_WORDS = NUM_WORDS_DEF
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [WORD_W*NUM_WORDS-1:0]   in_a,
    input  logic [WORD_W*NUM_WORDS-1:0]   in_b,
    input  logic                          in_sub,
    input  logic                          in_cin,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [WORD_W*NUM_WORDS-1:0]   out_sum,
    output logic                          out_cout,
    output logic                          out_ovf
);

    localparam int unsigned N     = WORD_W * NUM_WORDS;
    localparam int unsigned IDX_W = idx_width(NUM_WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             carry_q, carry_d;
    logic [N-1:0]     a_q, a_d;
    logic [N-1:0]     b_q, b_d;
    logic [N-1:0]     sum_q, sum_d;

    logic [WORD_W-1:0] slice_a, slice_b, slice_sum;
    logic              slice_cout, slice_cmsb;

    assign slice_a = a_q[idx_q*WORD_W +: WORD_W];
    assign slice_b = b_q[idx_q*WORD_W +: WORD_W];

    // Single shared slice; word-to-word carry only via carry_q.
    mp_word_adder #(
        .WORD_W (WORD_W)
    ) u_slice (
        .a_i     (slice_a),
        .b_i     (slice_b),
        .cin_i   (carry_q),
        .sum_o   (slice_sum),
        .cout_o  (slice_cout),
        .c_msb_o (slice_cmsb)
    );

    // Next-state logic for the sequencer and its datapath registers.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    // Subtract as A + ~B + 1.
                    a_d     = in_a;
                    b_d     = in_b ^ {N{in_sub}};
                    carry_d = in_sub | in_cin;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d[idx_q*WORD_W +: WORD_W] = slice_sum;
                carry_d = slice_cout;
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out_sum   = sum_q;
    // After the last word carry_q holds the top-word carry-out until the next accept.
    assign out_cout  = carry_q;

`ifdef MP_ADD_OVF_EN
    logic ovf_q, ovf_d;

    // Capture signed overflow from the top word in the last RUN cycle.
    always_comb begin
        ovf_d = ovf_q;
        if (state_q == RUN && idx_q == LAST_IDX) begin
            ovf_d = slice_cmsb ^ slice_cout;
        end
    end

    // Overflow flag register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign out_ovf = ovf_q;
`else
    logic unused_cmsb;
    assign unused_cmsb = slice_cmsb;
    assign out_ovf     = 1'b0;
`endif

endmodule
